// File: rtl/imem_arbiter.sv
// Shares one single-port instruction memory between the fetch unit and the loader.
// Define IMEM_ARB_RR_EN to use round-robin on conflicts; without it the loader always wins.
module imem_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_f_req,
    input  logic [31:0]       i_f_addr,
    output logic              o_f_gnt,
    output logic              o_f_rvalid,
    output logic [DATA_W-1:0] o_f_rdata,
    input  logic              i_l_req,
    input  logic              i_l_we,
    input  logic              i_l_lock,
    input  logic [31:0]       i_l_addr,
    input  logic [DATA_W-1:0] i_l_wdata,
    output logic              o_l_gnt,
    output logic              o_l_rvalid,
    output logic [DATA_W-1:0] o_l_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [15:0]       o_f_cnt,
    output logic [15:0]       o_l_cnt
);
    typedef enum logic {ST_OPEN = 1'b0, ST_LOCKED = 1'b1} lock_state_t;

    lock_state_t       r_state;
    logic              r_f_rvalid;
    logic              r_l_rvalid;
    logic [DATA_W-1:0] r_f_rdata;
    logic [DATA_W-1:0] r_l_rdata;
    logic [15:0]       r_f_cnt;
    logic [15:0]       r_l_cnt;
    logic              w_f_gnt;
    logic              w_l_gnt;
    logic              w_l_wins;
    logic              w_unused;

`ifdef IMEM_ARB_RR_EN
    logic r_last_l;  // 1 when the loader owned the most recent grant
    assign w_l_wins = ~r_last_l;
`else
    assign w_l_wins = 1'b1;
`endif

    // Only the word-index bits of the byte addresses reach the memory.
    assign w_unused = ^{i_f_addr[31:ADDR_W+2], i_f_addr[1:0],
                        i_l_addr[31:ADDR_W+2], i_l_addr[1:0]};

    // Grant decision from live requests plus lock / last-owner state.
    always_comb begin
        w_f_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (!i_reset) begin
            if (r_state == ST_LOCKED) begin
                w_l_gnt = i_l_req;
            end else if (i_f_req && i_l_req) begin
                w_l_gnt = w_l_wins;
                w_f_gnt = ~w_l_wins;
            end else begin
                w_f_gnt = i_f_req;
                w_l_gnt = i_l_req;
            end
        end
    end

    assign o_f_gnt     = w_f_gnt;
    assign o_l_gnt     = w_l_gnt;
    assign o_mem_addr  = w_l_gnt ? i_l_addr[ADDR_W+1:2] :
                         w_f_gnt ? i_f_addr[ADDR_W+1:2] : '0;
    assign o_mem_we    = w_l_gnt & i_l_we;
    assign o_mem_wdata = i_reset ? '0 : i_l_wdata;

    // Memory data is live in the rvalid cycle; otherwise replay the last returned word.
    assign o_f_rvalid = r_f_rvalid & ~i_reset;
    assign o_l_rvalid = r_l_rvalid & ~i_reset;
    assign o_f_rdata  = i_reset ? '0 : (r_f_rvalid ? i_mem_rdata : r_f_rdata);
    assign o_l_rdata  = i_reset ? '0 : (r_l_rvalid ? i_mem_rdata : r_l_rdata);
    assign o_f_cnt    = r_f_cnt;
    assign o_l_cnt    = r_l_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_OPEN;
            r_f_rvalid <= 1'b0;
            r_l_rvalid <= 1'b0;
            r_f_rdata  <= '0;
            r_l_rdata  <= '0;
            r_f_cnt    <= 16'd0;
            r_l_cnt    <= 16'd0;
`ifdef IMEM_ARB_RR_EN
            r_last_l   <= 1'b0;
`endif
        end else begin
            r_f_rvalid <= w_f_gnt;
            r_l_rvalid <= w_l_gnt & ~i_l_we;
            if (r_f_rvalid) r_f_rdata <= i_mem_rdata;
            if (r_l_rvalid) r_l_rdata <= i_mem_rdata;
            if (w_f_gnt && (r_f_cnt != 16'hFFFF)) r_f_cnt <= r_f_cnt + 16'd1;
            if (w_l_gnt && (r_l_cnt != 16'hFFFF)) r_l_cnt <= r_l_cnt + 16'd1;
            case (r_state)
                ST_OPEN:   if (w_l_gnt && i_l_lock) r_state <= ST_LOCKED;
                ST_LOCKED: if (!i_l_lock)           r_state <= ST_OPEN;
                default:                            r_state <= ST_OPEN;
            endcase
`ifdef IMEM_ARB_RR_EN
            if (w_l_gnt)      r_last_l <= 1'b1;
            else if (w_f_gnt) r_last_l <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: vector table, lock/reset sequences, counter saturation.
module tb_imem_arbiter;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
`ifdef IMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              f_req, l_req, l_we, l_lock;
    logic [31:0]       f_addr, l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              f_gnt, f_rvalid, l_gnt, l_rvalid, mem_we;
    logic [DATA_W-1:0] f_rdata, l_rdata, mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       f_cnt, l_cnt;

    imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clock(clk), .i_reset(reset),
        .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt),
        .o_f_rvalid(f_rvalid), .o_f_rdata(f_rdata),
        .i_l_req(l_req), .i_l_we(l_we), .i_l_lock(l_lock), .i_l_addr(l_addr),
        .i_l_wdata(l_wdata), .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
        .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .o_f_cnt(f_cnt), .o_l_cnt(l_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory fixture; reloads a known pattern while reset is high.
    logic [DATA_W-1:0] mem [1024];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= {16'hC0DE, 16'(i)};
            mem[4] <= 32'hDEADBEEF;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        l_req, l_we, l_lock;
        logic [31:0] l_addr, l_wdata;
        logic        e_fg, e_lg;
        logic [9:0]  e_maddr;
        logic        e_we;
        logic [31:0] e_data;
    } vec_t;

    typedef struct {
        logic        fv, lv;
        logic [31:0] data;
    } resp_t;

    resp_t       sb[$];
    vec_t        tbl[$];
    int          n_chk = 0, n_pass = 0;
    int          exp_f_cnt = 0, exp_l_cnt = 0;
    logic [31:0] f_hold = '0, l_hold = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic vec_t mk(input logic fr, input logic [31:0] fa, input logic lr,
                                input logic lw, input logic lk, input logic [31:0] la,
                                input logic [31:0] ld, input logic efg, input logic elg,
                                input logic [9:0] ema, input logic ewe, input logic [31:0] ed);
        vec_t v;
        v.f_req = fr; v.f_addr = fa; v.l_req = lr; v.l_we = lw; v.l_lock = lk;
        v.l_addr = la; v.l_wdata = ld; v.e_fg = efg; v.e_lg = elg;
        v.e_maddr = ema; v.e_we = ewe; v.e_data = ed;
        return v;
    endfunction

    // One cycle: drive, check combinational grant side, retire last cycle's read response.
    task automatic apply(input vec_t v, input string tag);
        resp_t e, n;
        @(posedge clk); #1;
        reset = 1'b0;
        f_req = v.f_req; f_addr = v.f_addr; l_req = v.l_req; l_we = v.l_we;
        l_lock = v.l_lock; l_addr = v.l_addr; l_wdata = v.l_wdata;
        @(negedge clk);
        chk({tag, "/f_gnt"}, 32'(f_gnt), 32'(v.e_fg));
        chk({tag, "/l_gnt"}, 32'(l_gnt), 32'(v.e_lg));
        chk({tag, "/mem_addr"}, 32'(mem_addr), 32'(v.e_maddr));
        chk({tag, "/mem_we"}, 32'(mem_we), 32'(v.e_we));
        if (v.e_we) chk({tag, "/mem_wdata"}, mem_wdata, v.l_wdata);
        chk({tag, "/f_cnt"}, 32'(f_cnt), 32'(exp_f_cnt));
        chk({tag, "/l_cnt"}, 32'(l_cnt), 32'(exp_l_cnt));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "/f_rvalid"}, 32'(f_rvalid), 32'(e.fv));
            chk({tag, "/l_rvalid"}, 32'(l_rvalid), 32'(e.lv));
            if (e.fv) f_hold = e.data;
            if (e.lv) l_hold = e.data;
            chk({tag, "/f_rdata"}, f_rdata, f_hold);
            chk({tag, "/l_rdata"}, l_rdata, l_hold);
        end
        n.fv = v.e_fg;
        n.lv = v.e_lg & ~v.l_we;
        n.data = v.e_data;
        sb.push_back(n);
        if (v.e_fg) exp_f_cnt++;
        if (v.e_lg) exp_l_cnt++;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic lg;
        // Reset with every request asserted: nothing may leak out.
        reset = 1'b1; f_req = 1'b1; l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1;
        f_addr = 32'h10; l_addr = 32'hFFC; l_wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst/f_gnt", 32'(f_gnt), 32'd0);
        chk("rst/l_gnt", 32'(l_gnt), 32'd0);
        chk("rst/mem_addr", 32'(mem_addr), 32'd0);
        chk("rst/mem_we", 32'(mem_we), 32'd0);
        chk("rst/mem_wdata", mem_wdata, 32'd0);
        chk("rst/f_rvalid", 32'(f_rvalid), 32'd0);
        chk("rst/l_rvalid", 32'(l_rvalid), 32'd0);
        chk("rst/f_rdata", f_rdata, 32'd0);
        chk("rst/l_rdata", l_rdata, 32'd0);
        chk("rst/f_cnt", 32'(f_cnt), 32'd0);
        chk("rst/l_cnt", 32'(l_cnt), 32'd0);

        // Four-cycle conflict first so the round-robin build starts from a fresh last owner.
        for (int i = 0; i < 4; i++) begin
            lg = RR ? ((i % 2) == 0) : 1'b1;
            tbl.push_back(mk(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, ~lg, lg,
                             10'(lg ? 2 : 1), 1'b0, lg ? 32'hC0DE0002 : 32'hC0DE0001));
        end
        tbl.push_back(mk(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'd4, 1'b0, 32'hDEADBEEF));
        tbl.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hFFC, 32'h12345678, 1'b0, 1'b1, 10'd1023, 1'b1, 32'h0));
        tbl.push_back(mk(1'b1, 32'hFFC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'd1023, 1'b0, 32'h12345678));
        tbl.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'hFFFFF023, 32'h0, 1'b0, 1'b1, 10'd8, 1'b0, 32'hC0DE0008));
        tbl.push_back(mk(1'b1, 32'hABCDE017, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'd5, 1'b0, 32'hC0DE0005));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Lock: loader read with lock, then the fetch side is shut out until lock drops.
        apply(mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0, 1'b1, 10'd2, 1'b0, 32'hC0DE0002), "lock_rd");
        for (int i = 0; i < 3; i++)
            apply(mk(1'b1, 32'h4, 1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0, 1'b1, 10'd2, 1'b0, 32'hC0DE0002),
                  $sformatf("locked%0d", i));
        apply(mk(1'b1, 32'h4, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0), "locked_fonly");
        apply(mk(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 10'd2, 1'b0, 32'hC0DE0002), "unlock");
        apply(mk(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 10'd1, 1'b0, 32'hC0DE0001), "post_unlock");
        apply(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 10'd0, 1'b0, 32'h0), "drain");

        // Reset arriving the cycle after a granted fetch read kills the response.
        sb.delete();
        @(posedge clk); #1;
        f_req = 1'b1; f_addr = 32'h10; l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
        @(negedge clk);
        chk("rst_mid/f_gnt", 32'(f_gnt), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1; f_req = 1'b0;
        @(negedge clk);
        chk("rst_mid/f_rvalid_in_reset", 32'(f_rvalid), 32'd0);
        chk("rst_mid/f_rdata_in_reset", f_rdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid/f_rvalid_after", 32'(f_rvalid), 32'd0);
        chk("rst_mid/f_cnt", 32'(f_cnt), 32'd0);
        chk("rst_mid/l_cnt", 32'(l_cnt), 32'd0);

        // 65537 back-to-back fetch grants must pin the counter at its ceiling.
        @(posedge clk); #1;
        f_req = 1'b1; f_addr = 32'h0;
        repeat (65537) @(posedge clk);
        @(negedge clk);
        chk("sat/f_cnt", 32'(f_cnt), 32'h0000FFFF);
        chk("sat/l_cnt", 32'(l_cnt), 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sat/f_cnt_hold", 32'(f_cnt), 32'h0000FFFF);
        f_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width (1024 words = 4096 bytes).
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 clock  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 f_req  in  1  fetch read request.
REQ-006 f_addr  in  32  fetch byte address.
REQ-007 f_gnt  out  1  fetch request accepted this cycle.
REQ-008 f_rvalid  out  1  fetch read data valid.
REQ-009 f_rdata  out  DATA_W  fetch read data.
REQ-010 l_req  in  1  loader request, read or write.
REQ-011 l_we  in  1  loader write enable, qualified by l_req.
REQ-012 l_lock  in  1  loader exclusive-access request.
REQ-013 l_addr  in  32  loader byte address.
REQ-014 l_wdata  in  DATA_W  loader write data.
REQ-015 l_gnt  out  1  loader request accepted this cycle.
REQ-016 l_rvalid  out  1  loader read data valid.
REQ-017 l_rdata  out  DATA_W  loader read data.
REQ-018 mem_addr  out  ADDR_W  memory word address.
REQ-019 mem_we  out  1  memory write strobe.
REQ-020 mem_wdata  out  DATA_W  memory write data.
REQ-021 mem_rdata  in  DATA_W  memory read data, valid one cycle after the address is presented.
REQ-022 f_cnt, l_cnt  out  16  per-requester grant counters.

Function
REQ-023 Grant SHALL be combinational from the current requests and registered arbitration state; a transfer occurs when req and gnt are both high.
REQ-024 At most one of f_gnt/l_gnt SHALL be high per cycle; gnt SHALL never be high without its req.
REQ-025 mem_addr SHALL be the granted requester's addr[ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 are ignored. mem_addr SHALL be 0 when nothing is granted.
REQ-026 mem_we SHALL equal l_gnt AND l_we; mem_wdata SHALL equal l_wdata; fetch never writes.
REQ-027 A granted read SHALL raise the owner's rvalid exactly one cycle later, with rdata = mem_rdata; the other rvalid stays low.
REQ-028 A granted write SHALL produce no rvalid.
REQ-029 Back-to-back grants SHALL be supported, one transfer per cycle, with no bubble.
REQ-030 rdata outputs SHALL hold their last valid value while rvalid is low.
REQ-031 The lock state machine SHALL have two states. OPEN goes to LOCKED on an l_gnt with l_lock=1. LOCKED goes to OPEN on any cycle with l_lock=0.
REQ-032 While LOCKED, f_gnt SHALL be 0 and l_req SHALL always be granted.
REQ-033 Arbitration when both request in OPEN: see Configuration.
REQ-034 Each counter SHALL increment on its own gnt and saturate at 16'hFFFF without wrapping.
REQ-035 A read and a write to the same address in consecutive cycles SHALL return memory-native data; the arbiter does no forwarding.

Reset
REQ-036 On reset, all outputs SHALL be 0: gnt, rvalid, rdata, mem_*, and both counters.
REQ-037 On reset, the state SHALL be OPEN and the last-owner register SHALL be 0 (fetch).
REQ-038 A read granted in the cycle before reset SHALL NOT produce rvalid in the reset cycle or afterwards.

Configuration
REQ-039 Macro IMEM_ARB_RR_EN defined: round-robin arbitration.
  - On a conflict, grant the requester that was not the last owner.
  - The last owner updates on every grant.
REQ-040 Macro IMEM_ARB_RR_EN undefined: fixed priority, loader wins every conflict. The last-owner register is absent or unused.

Verification
REQ-041 Fetch-only read: f_req=1, f_addr=0x10, mem holds word4=0xDEADBEEF.
  - Required: f_gnt=1 in cycle N.
  - Required: f_rvalid=1 and f_rdata=0xDEADBEEF in N+1.
  - Required: mem_addr=4 in N.
REQ-042 Loader write then fetch read: loader writes 0x12345678 to 0xFFC.
  - Required: mem_we=1 and mem_addr=1023 for one cycle.
  - Required: l_rvalid stays 0.
  - Required: a subsequent fetch of 0xFFC returns 0x12345678.
REQ-043 Both request for 4 cycles.
  - Without IMEM_ARB_RR_EN: l_gnt=1 on all 4 cycles and f_gnt=0.
  - With IMEM_ARB_RR_EN: grants alternate L,F,L,F, starting with L after reset.
REQ-044 Lock: loader read with l_lock=1, then fetch and loader both request for 3 cycles.
  - Required: f_gnt=0 throughout.
  - Required: after l_lock drops, f_gnt=1 the next cycle it is requested without conflict.
REQ-045 Reset mid-read: grant a fetch read in cycle N, assert reset in N+1.
  - Required: f_rvalid=0 in N+1 and after.
  - Required: f_cnt=0 after reset.
REQ-046 Counter saturation: preload or drive 65537 fetch grants.
  - Required: f_cnt=0xFFFF and it holds there.
